// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-serial program loader, a fetch read port and a debug read port.
// After reset the whole array is swept to zero before the fetch side reports ready.
module instr_mem_loader #(
    parameter int                NBITS     = 32,
    parameter int                CELDAS    = 160,
    parameter logic [NBITS-1:0]  HALT_WORD = {NBITS{1'b1}},
    parameter int                AW        = $clog2(CELDAS + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [NBITS-1:0] i_PC,
    output logic [NBITS-1:0] o_Instruction,
    input  logic             i_LoadStart,
    input  logic             i_LoadValid,
    input  logic [7:0]       i_LoadByte,
    output logic             o_LoadReady,
    input  logic [NBITS-1:0] i_DirecDebug,
    output logic [NBITS-1:0] o_DebugInst,
    output logic             o_Ready,
    output logic             o_LoadDone,
    output logic             o_Overflow,
    output logic [AW-1:0]    o_WordCount,
    output logic [1:0]       o_State
);

    localparam int LANES = NBITS / 8;
    localparam int SH    = $clog2(LANES);
    localparam int MW    = (CELDAS > 1) ? $clog2(CELDAS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [AW-1:0]    LAST_ADDR = AW'(CELDAS - 1);
    localparam logic [LW-1:0]    LAST_LANE = LW'(LANES - 1);
    localparam logic [NBITS-1:0] DEPTH_W   = NBITS'(CELDAS);

    typedef enum logic [1:0] {CLEAR, IDLE, LOAD, DONE} state_t;

    state_t            state_q;
    logic [AW-1:0]     clr_ptr_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [LW-1:0]     lane_q;
    logic [NBITS-1:0]  word_q;
    logic [NBITS-1:0]  word_d;
    logic [NBITS-1:0]  inst_q;
    logic [NBITS-1:0]  dbg_q;
    logic              load_ready_q;
    logic              ready_q;
    logic              done_q;
    logic              ovf_q;
    logic [AW-1:0]     count_q;

    logic [NBITS-1:0]  mem [CELDAS];

    logic              byte_acc;
    logic              last_byte;
    logic              mem_we;
    logic [MW-1:0]     mem_waddr;
    logic [NBITS-1:0]  mem_wdata;
    logic [NBITS-1:0]  fetch_idx;
    logic              fetch_hit;
    logic              dbg_hit;

    // Valid/ready: a load byte transfers on a rising edge where i_LoadValid and o_LoadReady are both 1.
    always_comb begin
        word_d                         = word_q;
        word_d[int'(lane_q) * 8 +: 8]  = i_LoadByte;
        byte_acc                       = load_ready_q & i_LoadValid;
        last_byte                      = byte_acc && (lane_q == LAST_LANE);
        fetch_idx                      = i_PC >> SH;
        fetch_hit                      = fetch_idx < DEPTH_W;
        dbg_hit                        = i_DirecDebug < DEPTH_W;
        mem_we                         = 1'b0;
        mem_waddr                      = '0;
        mem_wdata                      = '0;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q[MW-1:0];
        end else if (last_byte) begin
            mem_we    = 1'b1;
            mem_waddr = wr_ptr_q[MW-1:0];
            mem_wdata = word_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= CLEAR;
            clr_ptr_q    <= '0;
            wr_ptr_q     <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            inst_q       <= '0;
            dbg_q        <= '0;
            load_ready_q <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            // Reads sample the array before this edge's write lands, giving read-first behaviour.
            if (state_q == CLEAR || state_q == LOAD) begin
                inst_q <= '0;
            end else if (i_enable) begin
                inst_q <= fetch_hit ? mem[fetch_idx[MW-1:0]] : '0;
            end
            dbg_q <= dbg_hit ? mem[i_DirecDebug[MW-1:0]] : '0;

            case (state_q)
                CLEAR: begin
                    if (clr_ptr_q == LAST_ADDR) begin
                        state_q   <= IDLE;
                        ready_q   <= 1'b1;
                        clr_ptr_q <= '0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                IDLE, DONE: begin
                    if (i_LoadStart) begin
                        state_q      <= LOAD;
                        wr_ptr_q     <= '0;
                        lane_q       <= '0;
                        count_q      <= '0;
                        done_q       <= 1'b0;
                        ovf_q        <= 1'b0;
                        load_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (last_byte) begin
                        lane_q   <= '0;
                        word_q   <= '0;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        count_q  <= count_q + 1'b1;
                        if (word_d == HALT_WORD) begin
                            state_q      <= DONE;
                            done_q       <= 1'b1;
                            load_ready_q <= 1'b0;
                        end else if (wr_ptr_q == LAST_ADDR) begin
                            state_q      <= DONE;
                            done_q       <= 1'b1;
                            ovf_q        <= 1'b1;
                            load_ready_q <= 1'b0;
                        end
                    end else if (byte_acc) begin
                        lane_q <= lane_q + 1'b1;
                        word_q <= word_d;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign o_Instruction = inst_q;
    assign o_DebugInst   = dbg_q;
    assign o_LoadReady   = load_ready_q;
    assign o_Ready       = ready_q;
    assign o_LoadDone    = done_q;
    assign o_Overflow    = ovf_q;
    assign o_WordCount   = count_q;
    assign o_State       = state_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: clear sweep, byte loads, halt/overflow endings, fetch/debug reads, reset mid-load.
module tb_instr_mem_loader;

    localparam int NBITS  = 32;
    localparam int CELDAS = 160;
    localparam int AW     = $clog2(CELDAS + 1);

    logic              clk;
    logic              i_reset;
    logic              i_enable;
    logic [NBITS-1:0]  i_PC;
    logic [NBITS-1:0]  o_Instruction;
    logic              i_LoadStart;
    logic              i_LoadValid;
    logic [7:0]        i_LoadByte;
    logic              o_LoadReady;
    logic [NBITS-1:0]  i_DirecDebug;
    logic [NBITS-1:0]  o_DebugInst;
    logic              o_Ready;
    logic              o_LoadDone;
    logic              o_Overflow;
    logic [AW-1:0]     o_WordCount;
    logic [1:0]        o_State;

    logic [NBITS-1:0]  exp_q[$];
    logic [NBITS-1:0]  model [CELDAS];
    int                checks;
    int                failures;

    instr_mem_loader #(.NBITS(NBITS), .CELDAS(CELDAS)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_PC          (i_PC),
        .o_Instruction (o_Instruction),
        .i_LoadStart   (i_LoadStart),
        .i_LoadValid   (i_LoadValid),
        .i_LoadByte    (i_LoadByte),
        .o_LoadReady   (o_LoadReady),
        .i_DirecDebug  (i_DirecDebug),
        .o_DebugInst   (o_DebugInst),
        .o_Ready       (o_Ready),
        .o_LoadDone    (o_LoadDone),
        .o_Overflow    (o_Overflow),
        .o_WordCount   (o_WordCount),
        .o_State       (o_State)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int a = 0; a < CELDAS; a++) model[a] = '0;
    endtask

    // Releases reset between edges and counts edges until o_Ready rises.
    task automatic release_and_wait(input string tag);
        int n;
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        n = 0;
        while (!o_Ready && n < 1000) begin
            step();
            n++;
        end
        check(tag, 32'(n), 32'(CELDAS));
    endtask

    task automatic debug_sweep(input string tag);
        for (int a = 0; a < CELDAS; a++) begin
            exp_q.push_back(model[a]);
            i_DirecDebug = 32'(a);
            step();
            check(tag, o_DebugInst, exp_q.pop_front());
        end
        i_DirecDebug = 32'd257;
        step();
        check("dbg_out_of_range", o_DebugInst, 32'h0);
    endtask

    task automatic start_load();
        i_LoadStart = 1'b1;
        step();
        i_LoadStart = 1'b0;
        check("load_ready_on", 32'(o_LoadReady), 32'h1);
    endtask

    // Drives one word as four bytes; the last byte's edge also reads the same address on the debug port.
    task automatic send_word(input logic [31:0] w, input int ptr, input bit gaps, input int pulse_lane);
        for (int k = 0; k < 4; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    i_LoadValid = 1'b0;
                    i_LoadByte  = 8'($urandom);
                    step();
                end
            end
            if (k == pulse_lane) begin
                i_LoadValid = 1'b0;
                i_LoadStart = 1'b1;
                step();
                i_LoadStart = 1'b0;
            end
            if (k == 3) begin
                i_DirecDebug = 32'(ptr);
                exp_q.push_back(model[ptr]);
            end
            i_LoadValid = 1'b1;
            i_LoadByte  = w[8*k +: 8];
            step();
            i_LoadValid = 1'b0;
        end
        check("read_first", o_DebugInst, exp_q.pop_front());
        model[ptr] = w;
    endtask

    initial begin
        logic [31:0] w;
        checks       = 0;
        failures     = 0;
        i_reset      = 1'b0;
        i_enable     = 1'b0;
        i_PC         = '0;
        i_LoadStart  = 1'b0;
        i_LoadValid  = 1'b0;
        i_LoadByte   = '0;
        i_DirecDebug = '0;
        #12;
        check("rst_ready", 32'(o_Ready), 32'h0);
        check("rst_inst", o_Instruction, 32'h0);
        check("rst_dbg", o_DebugInst, 32'h0);
        check("rst_load_ready", 32'(o_LoadReady), 32'h0);
        check("rst_done", 32'(o_LoadDone), 32'h0);
        check("rst_ovf", 32'(o_Overflow), 32'h0);
        check("rst_count", 32'(o_WordCount), 32'h0);
        check("rst_state", 32'(o_State), 32'h0);

        release_and_wait("clear_len");
        model_zero();
        debug_sweep("dbg_after_clear");

        // Two-word program ending in the halt word.
        start_load();
        send_word(32'h0020_0013, 0, 1'b1, -1);
        send_word(32'hFFFF_FFFF, 1, 1'b1, -1);
        check("halt_done", 32'(o_LoadDone), 32'h1);
        check("halt_count", 32'(o_WordCount), 32'd2);
        check("halt_ovf", 32'(o_Overflow), 32'h0);
        check("halt_load_ready", 32'(o_LoadReady), 32'h0);
        debug_sweep("dbg_prog1");

        // Fetch port: word index, ignored low bits, stall hold, out of range.
        i_enable = 1'b1;
        i_PC = 32'd4;   step(); check("fetch_pc4", o_Instruction, model[1]);
        i_PC = 32'd1;   step(); check("fetch_pc1", o_Instruction, model[0]);
        i_PC = 32'd4;   step();
        i_enable = 1'b0;
        i_PC = 32'd0;   step(); check("fetch_stall", o_Instruction, model[1]);
        i_enable = 1'b1;
        i_PC = 32'd640; step(); check("fetch_pc640", o_Instruction, 32'h0);
        i_PC = 32'h404; step(); check("fetch_pc1028", o_Instruction, 32'h0);
        i_PC = 32'd4;

        // Gappy load with a stray start request in the middle of a word.
        start_load();
        step();
        check("nop_in_load", o_Instruction, 32'h0);
        check("ready_in_load", 32'(o_Ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            w = $urandom & 32'h7FFF_FFFF;
            send_word(w, i, 1'b1, (i == 1) ? 2 : -1);
        end
        send_word(32'hFFFF_FFFF, 3, 1'b1, -1);
        check("gap_count", 32'(o_WordCount), 32'd4);
        check("gap_done", 32'(o_LoadDone), 32'h1);
        check("gap_ovf", 32'(o_Overflow), 32'h0);
        debug_sweep("dbg_prog2");

        // Fill every word without a halt.
        start_load();
        for (int i = 0; i < CELDAS; i++) begin
            w = $urandom & 32'h7FFF_FFFF;
            send_word(w, i, 1'b0, -1);
        end
        check("ovf_flag", 32'(o_Overflow), 32'h1);
        check("ovf_count", 32'(o_WordCount), 32'(CELDAS));
        check("ovf_done", 32'(o_LoadDone), 32'h1);
        check("ovf_load_ready", 32'(o_LoadReady), 32'h0);
        i_LoadValid = 1'b1;
        i_LoadByte  = 8'hAA;
        step();
        i_LoadValid = 1'b0;
        check("extra_byte_count", 32'(o_WordCount), 32'(CELDAS));
        check("extra_byte_state", 32'(o_State), 32'd3);
        debug_sweep("dbg_prog3");

        // Reset after two bytes of a word.
        start_load();
        i_LoadValid = 1'b1;
        i_LoadByte  = 8'h11; step();
        i_LoadByte  = 8'h22; step();
        i_LoadValid = 1'b0;
        #2;
        i_reset = 1'b0;
        #1;
        check("midrst_ready", 32'(o_Ready), 32'h0);
        check("midrst_load_ready", 32'(o_LoadReady), 32'h0);
        check("midrst_count", 32'(o_WordCount), 32'h0);
        check("midrst_state", 32'(o_State), 32'h0);
        check("midrst_inst", o_Instruction, 32'h0);
        release_and_wait("clear_len_2");
        model_zero();
        check("post_rst_count", 32'(o_WordCount), 32'h0);
        check("post_rst_done", 32'(o_LoadDone), 32'h0);
        debug_sweep("dbg_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter NBITS, 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter CELDAS, 160, depth in words.
REQ-003 Parameter HALT_WORD, {NBITS{1'b1}}, word value that terminates a program load.
REQ-004 Parameter AW, $clog2(CELDAS+1), width of the word counter.
REQ-005 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_enable  in  1  fetch enable; 0 = pipeline stall.
REQ-008 i_PC  in  NBITS  fetch byte address.
REQ-009 o_Instruction  out  NBITS  registered fetched word.
REQ-010 i_LoadStart  in  1  one-cycle request to begin a program load.
REQ-011 i_LoadValid  in  1  load byte valid.
REQ-012 i_LoadByte  in  8  load byte data.
REQ-013 o_LoadReady  out  1  block accepts a load byte this cycle.
REQ-014 i_DirecDebug  in  NBITS  debug read word index.
REQ-015 o_DebugInst  out  NBITS  registered debug read word.
REQ-016 o_Ready  out  1  memory cleared and usable.
REQ-017 o_LoadDone  out  1  last load finished.
REQ-018 o_Overflow  out  1  last load filled all CELDAS words without HALT_WORD.
REQ-019 o_WordCount  out  AW  words written by the current/last load.

Function
REQ-020 States SHALL be CLEAR, IDLE, LOAD, DONE.
REQ-021 CLEAR: zero one word per cycle at clear pointer 0..CELDAS-1; after writing CELDAS-1 -> IDLE; o_Ready=0 in CLEAR, 1 otherwise.
REQ-022 Fetch index = i_PC >> log2(NBITS/8); i_PC low bits ignored.
REQ-023 When o_Ready=1 and i_enable=1: o_Instruction <= mem[index], or 0 if index >= CELDAS; latency 1 cycle.
REQ-024 When i_enable=0: o_Instruction holds; in CLEAR or LOAD: o_Instruction <= 0 (NOP) regardless of i_enable.
REQ-025 i_LoadStart in IDLE or DONE -> LOAD; clears write pointer, byte lane, o_WordCount, o_LoadDone, o_Overflow; ignored in CLEAR and LOAD.
REQ-026 o_LoadReady = 1 exactly in LOAD; byte accepted when i_LoadValid & o_LoadReady.
REQ-027 Bytes assemble little-endian: first accepted byte -> bits [7:0], byte k -> bits [8k+7:8k]; lane wraps after NBITS/8 bytes.
REQ-028 On acceptance of the last lane byte: write assembled word to mem[pointer] same edge, pointer+1, o_WordCount+1.
REQ-029 If written word == HALT_WORD -> DONE, o_LoadDone=1 (halt word is stored and counted).
REQ-030 Else if pointer reaches CELDAS -> DONE, o_LoadDone=1, o_Overflow=1.
REQ-031 Partial word (fewer than NBITS/8 bytes) is never written.
REQ-032 o_DebugInst <= mem[i_DirecDebug] every cycle, 0 if >= CELDAS; latency 1; valid in all states.
REQ-033 Same-cycle write and read of one address (fetch or debug) SHALL return old contents (read-first).
REQ-034 Memory SHALL be a single write-port array; only CLEAR and LOAD write it.

Reset
REQ-035 i_reset=0 asynchronously forces: state CLEAR, clear pointer 0, write pointer 0, byte lane 0, o_Instruction=0, o_DebugInst=0, o_LoadReady=0, o_Ready=0, o_LoadDone=0, o_Overflow=0, o_WordCount=0.
REQ-036 Reset mid-LOAD discards the partial word and SHALL re-run the full CLEAR sweep after release.
REQ-037 Memory contents need not be zeroed by the asynchronous edge itself; CLEAR guarantees zero before o_Ready=1.

Verification
REQ-038 Release reset -> o_Ready rises exactly CELDAS cycles later; every debug read 0..CELDAS-1 returns 0.
REQ-039 Load bytes 0x13,0x00,0x20,0x00,FF,FF,FF,FF -> mem[0]=0x00200013, mem[1]=0xFFFFFFFF, o_WordCount=2, o_LoadDone=1, o_Overflow=0.
REQ-040 Load 160 non-halt words -> o_Overflow=1, o_WordCount=160, o_LoadReady=0 next cycle; 641st byte not accepted.
REQ-041 After load, i_PC=4, i_enable=1 -> o_Instruction=mem[1] next cycle; i_enable=0, i_PC=0 -> o_Instruction unchanged; i_PC=640 -> 0.
REQ-042 i_LoadValid toggling with gaps -> identical stored words; i_LoadStart during LOAD ignored.
REQ-043 Reset asserted after 2 bytes of a word -> after CELDAS cycles all words 0, o_WordCount=0.
